// File: rtl/tilt_pkg.sv
// Shared types, default parameters and width helpers for the tilt character decoder.
package tilt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_EMIT,
    ST_WAIT_NEUTRAL
  } tilt_state_e;

  localparam int DEF_DATA_W      = 12;
  localparam int DEF_NUM_AXES    = 3;
  localparam int DEF_NUM_BANDS   = 2;
  localparam int DEF_BAND_LO     = 550;
  localparam int DEF_BAND_STEP   = 50;
  localparam int DEF_HOLD_CYCLES = 4;
  localparam int DEF_NEUTRAL_MAX = 200;
  localparam logic [7:0] DEF_CHAR_BASE = 8'h41;

  // Width of a band index within one axis (at least 1 bit).
  function automatic int band_idx_w(input int num_bands);
    int w;
    w = $clog2(num_bands);
    return (w < 1) ? 1 : w;
  endfunction

  // Width of the flattened candidate index k*NUM_BANDS+b (at least 1 bit).
  function automatic int cand_idx_w(input int num_axes, input int num_bands);
    int w;
    w = $clog2(num_axes * num_bands);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/tilt_band_classifier.sv
// Maps one signed axis sample to a tilt band (if any) and a neutral flag.
module tilt_band_classifier #(
  parameter int DATA_W      = 12,
  parameter int NUM_BANDS   = 2,
  parameter int BAND_LO     = 550,
  parameter int BAND_STEP   = 50,
  parameter int NEUTRAL_MAX = 200,
  parameter int BAND_W      = 1
) (
  input  logic [DATA_W-1:0] sample,
  output logic              qualify,
  output logic [BAND_W-1:0] band,
  output logic              neutral
);

  localparam logic signed [DATA_W:0] MAG_MAX   = (DATA_W+1)'((1 << (DATA_W-1)) - 1);
  localparam logic signed [DATA_W:0] NEUTRAL_T = (DATA_W+1)'(NEUTRAL_MAX);

  logic signed [DATA_W:0] val_x;
  logic signed [DATA_W:0] mag_x;

  // Lower edge of band idx, held at one bit wider than the sample.
  function automatic logic signed [DATA_W:0] band_edge(input int idx);
    return (DATA_W+1)'(BAND_LO + idx * BAND_STEP);
  endfunction

  assign val_x = $signed({sample[DATA_W-1], sample});

  // Band search: bands are disjoint, last band has no upper edge.
  always_comb begin
    qualify = 1'b0;
    band    = '0;
    for (int unsigned b = 0; b < NUM_BANDS; b++) begin
      if (!val_x[DATA_W] && (val_x >= band_edge(int'(b))) &&
          ((int'(b) == NUM_BANDS - 1) || (val_x < band_edge(int'(b) + 1)))) begin
        qualify = 1'b1;
        band    = BAND_W'(b);
      end
    end
  end

  // Saturating magnitude for the neutral test.
  always_comb begin
    if (sample == {1'b1, {(DATA_W-1){1'b0}}}) begin
      mag_x = MAG_MAX;
    end else if (val_x[DATA_W]) begin
      mag_x = -val_x;
    end else begin
      mag_x = val_x;
    end
    neutral = (mag_x <= NEUTRAL_T);
  end

endmodule

// File: rtl/tilt_char_decoder.sv
// Decodes held tilt gestures on several axes into single ASCII character strobes.
module tilt_char_decoder #(
  parameter int         DATA_W      = tilt_pkg::DEF_DATA_W,
  parameter int         NUM_AXES    = tilt_pkg::DEF_NUM_AXES,
  parameter int         NUM_BANDS   = tilt_pkg::DEF_NUM_BANDS,
  parameter int         BAND_LO     = tilt_pkg::DEF_BAND_LO,
  parameter int         BAND_STEP   = tilt_pkg::DEF_BAND_STEP,
  parameter int         HOLD_CYCLES = tilt_pkg::DEF_HOLD_CYCLES,
  parameter int         NEUTRAL_MAX = tilt_pkg::DEF_NEUTRAL_MAX,
  parameter logic [7:0] CHAR_BASE   = tilt_pkg::DEF_CHAR_BASE
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [NUM_AXES*DATA_W-1:0] axis_in,
  output logic [7:0]                 ascii_out,
  output logic                       valid,
  output logic                       armed
);
  import tilt_pkg::*;

  localparam int BAND_W = band_idx_w(NUM_BANDS);
  localparam int IDX_W  = cand_idx_w(NUM_AXES, NUM_BANDS);

  logic [NUM_AXES*DATA_W-1:0] s0_d, s0_q;
  tilt_state_e                state_d, state_q;
  logic [7:0]                 cnt_d, cnt_q;
  logic [IDX_W-1:0]           cand_d, cand_q;
  logic [7:0]                 ascii_d, ascii_q;
  logic                       valid_d, valid_q;
  logic                       armed_d, armed_q;

  logic [NUM_AXES-1:0]        ax_qual;
  logic [NUM_AXES-1:0]        ax_neutral;
  logic [BAND_W-1:0]          ax_band [NUM_AXES];
  logic                       cand_valid;
  logic [IDX_W-1:0]           cand_idx;
  logic                       all_neutral;

  assign s0_d = axis_in;

  for (genvar k = 0; k < NUM_AXES; k++) begin : g_axis
    tilt_band_classifier #(
      .DATA_W      (DATA_W),
      .NUM_BANDS   (NUM_BANDS),
      .BAND_LO     (BAND_LO),
      .BAND_STEP   (BAND_STEP),
      .NEUTRAL_MAX (NEUTRAL_MAX),
      .BAND_W      (BAND_W)
    ) u_cls (
      .sample  (s0_q[k*DATA_W +: DATA_W]),
      .qualify (ax_qual[k]),
      .band    (ax_band[k]),
      .neutral (ax_neutral[k])
    );
  end

  assign all_neutral = &ax_neutral;

  // Priority select: lowest-numbered qualifying axis supplies the candidate.
  always_comb begin
    cand_valid = 1'b0;
    cand_idx   = '0;
    for (int unsigned k = 0; k < NUM_AXES; k++) begin
      if (ax_qual[k] && !cand_valid) begin
        cand_valid = 1'b1;
        cand_idx   = IDX_W'(int'(k) * NUM_BANDS + int'(ax_band[k]));
      end
    end
  end

  // Next-state and output logic for the hold/emit/re-arm sequence.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    ascii_d = ascii_q;
    valid_d = 1'b0;
    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (cand_valid) begin
            cand_d = cand_idx;
            cnt_d  = 8'd1;
            // Loading the counter with 1 already meets a one-cycle hold,
            // so skip HOLD to keep latency uniform across HOLD_CYCLES.
            state_d = (HOLD_CYCLES <= 1) ? ST_EMIT : ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (!cand_valid) begin
            state_d = ST_IDLE;
          end else if (cand_idx != cand_q) begin
            cand_d = cand_idx;
            cnt_d  = 8'd1;
          end else begin
            cnt_d = cnt_q + 8'd1;
            if (({1'b0, cnt_q} + 9'd1) >= 9'(HOLD_CYCLES)) begin
              state_d = ST_EMIT;
            end
          end
        end
        ST_EMIT: begin
          valid_d = 1'b1;
          ascii_d = CHAR_BASE + 8'(cand_q);
          state_d = ST_WAIT_NEUTRAL;
        end
        ST_WAIT_NEUTRAL: begin
          if (all_neutral) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    armed_d = (state_d == ST_IDLE);
  end

  // State, sample stage and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s0_q    <= '0;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cand_q  <= '0;
      ascii_q <= '0;
      valid_q <= 1'b0;
      armed_q <= 1'b1;
    end else begin
      s0_q    <= s0_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
      ascii_q <= ascii_d;
      valid_q <= valid_d;
      armed_q <= armed_d;
    end
  end

  assign ascii_out = ascii_q;
  assign valid     = valid_q;
  assign armed     = armed_q;

endmodule

// File: tb/tb_tilt_char_decoder.sv
// Directed bench for tilt_char_decoder: default build plus a 4-axis/3-band/hold-1 build.
module tb_tilt_char_decoder;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        enable_sw;
  logic [35:0] axis_in;
  logic [47:0] axis_sw;
  logic [7:0]  ascii_out, ascii_sw;
  logic        valid, valid_sw;
  logic        armed, armed_sw;

  int n_cmp = 0;
  int n_mis = 0;
  int cyc = 0;
  int n_pulse = 0, last_cyc = 0;
  int n_pulse_sw = 0, last_cyc_sw = 0;
  logic [7:0] last_ascii = '0, last_ascii_sw = '0;
  int p, c0;

  tilt_char_decoder u_dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .axis_in   (axis_in),
    .ascii_out (ascii_out),
    .valid     (valid),
    .armed     (armed)
  );

  tilt_char_decoder #(
    .NUM_AXES    (4),
    .NUM_BANDS   (3),
    .HOLD_CYCLES (1)
  ) u_sw (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable_sw),
    .axis_in   (axis_sw),
    .ascii_out (ascii_sw),
    .valid     (valid_sw),
    .armed     (armed_sw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #2;
    if (valid) begin
      n_pulse++;
      last_cyc   = cyc;
      last_ascii = ascii_out;
    end
    if (valid_sw) begin
      n_pulse_sw++;
      last_cyc_sw   = cyc;
      last_ascii_sw = ascii_sw;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [35:0] pack3(input int x, input int y, input int z);
    return {12'(z), 12'(y), 12'(x)};
  endfunction

  function automatic logic [47:0] pack4(input int a0, input int a1, input int a2, input int a3);
    return {12'(a3), 12'(a2), 12'(a1), 12'(a0)};
  endfunction

  initial begin
    reset = 1'b1; enable = 1'b1; enable_sw = 1'b1;
    axis_in = '0; axis_sw = '0;
    run(3);
    check_val("rst_ascii", ascii_out, 8'h00);
    check_val("rst_valid", valid, 0);
    check_val("rst_armed", armed, 1);
    check_val("rst_armed_sw", armed_sw, 1);
    reset = 1'b0;
    run(2);

    // x=555 held: one 'A', valid after edge E+5
    p = n_pulse; c0 = cyc;
    axis_in = pack3(555, 0, 0);
    run(10);
    check_val("a_count", n_pulse - p, 1);
    check_val("a_char", last_ascii, 8'h41);
    check_val("a_latency", last_cyc, c0 + 6);
    check_val("a_hold_out", ascii_out, 8'h41);
    check_val("a_wait_armed", armed, 0);

    // neutral, then x=605: 'B'
    axis_in = pack3(0, 0, 0);
    run(3);
    check_val("neutral_armed", armed, 1);
    p = n_pulse;
    axis_in = pack3(605, 0, 0);
    run(10);
    check_val("b_count", n_pulse - p, 1);
    check_val("b_char", last_ascii, 8'h42);

    // still tilted: no re-emission
    p = n_pulse;
    axis_in = pack3(605, 555, 0);
    run(10);
    axis_in = pack3(300, 555, 0);
    run(10);
    check_val("tilted_no_pulse", n_pulse - p, 0);
    check_val("tilted_hold_out", ascii_out, 8'h42);

    // y=555 after neutral: 'C'
    axis_in = pack3(0, 0, 0);
    run(3);
    p = n_pulse;
    axis_in = pack3(0, 555, 0);
    run(10);
    check_val("c_count", n_pulse - p, 1);
    check_val("c_char", last_ascii, 8'h43);

    // x and z together: x wins
    axis_in = pack3(0, 0, 0);
    run(3);
    p = n_pulse;
    axis_in = pack3(555, 0, 555);
    run(10);
    check_val("prio_count", n_pulse - p, 1);
    check_val("prio_char", last_ascii, 8'h41);

    // candidate change mid-hold: single 'B'
    axis_in = pack3(0, 0, 0);
    run(3);
    p = n_pulse;
    axis_in = pack3(555, 0, 0);
    run(2);
    axis_in = pack3(605, 0, 0);
    run(5);
    axis_in = pack3(0, 0, 0);
    run(6);
    check_val("reload_count", n_pulse - p, 1);
    check_val("reload_char", last_ascii, 8'h42);

    // reset during HOLD discards the character
    p = n_pulse;
    axis_in = pack3(555, 0, 0);
    run(3);
    check_val("hold_not_armed", armed, 0);
    reset = 1'b1;
    axis_in = pack3(0, 0, 0);
    #1;
    check_val("rst_async_armed", armed, 1);
    check_val("rst_async_ascii", ascii_out, 8'h00);
    run(1);
    reset = 1'b0;
    run(10);
    check_val("rst_hold_no_pulse", n_pulse - p, 0);
    check_val("rst_hold_armed", armed, 1);
    check_val("rst_hold_ascii", ascii_out, 8'h00);

    // enable dropped during HOLD
    axis_in = pack3(605, 0, 0);
    run(10);
    axis_in = pack3(0, 0, 0);
    run(3);
    check_val("pre_en_char", ascii_out, 8'h42);
    p = n_pulse;
    axis_in = pack3(0, 555, 0);
    run(3);
    enable = 1'b0;
    run(1);
    check_val("en_low_armed", armed, 1);
    check_val("en_low_valid", valid, 0);
    run(8);
    check_val("en_low_no_pulse", n_pulse - p, 0);
    check_val("en_low_ascii", ascii_out, 8'h42);

    // enable falls as EMIT is reached: emission dropped
    axis_in = pack3(0, 0, 0);
    enable = 1'b1;
    run(3);
    p = n_pulse;
    axis_in = pack3(0, 555, 0);
    run(5);
    check_val("emit_state_armed", armed, 0);
    enable = 1'b0;
    run(3);
    check_val("emit_drop_count", n_pulse - p, 0);
    check_val("emit_drop_armed", armed, 1);
    check_val("emit_drop_ascii", ascii_out, 8'h42);
    enable = 1'b1;
    run(10);
    check_val("reenable_count", n_pulse - p, 1);
    check_val("reenable_char", last_ascii, 8'h43);

    // sweep build: axis 3 band 2 -> 'L', hold of one cycle
    p = n_pulse_sw; c0 = cyc;
    axis_sw = pack4(0, 0, 0, 655);
    run(6);
    check_val("sw_l_count", n_pulse_sw - p, 1);
    check_val("sw_l_char", last_ascii_sw, 8'h4C);
    check_val("sw_l_latency", last_cyc_sw, c0 + 3);

    // x=-2048 is not neutral, so no re-arm
    axis_sw = pack4(-2048, 0, 0, 0);
    run(6);
    check_val("sw_minneg_armed", armed_sw, 0);
    check_val("sw_minneg_count", n_pulse_sw - p, 1);
    axis_sw = pack4(0, 0, 0, 0);
    run(3);
    check_val("sw_neutral_armed", armed_sw, 1);

    // axis 1 band 1 -> index 4 -> 'E'
    p = n_pulse_sw;
    axis_sw = pack4(0, 610, 0, 0);
    run(6);
    check_val("sw_e_count", n_pulse_sw - p, 1);
    check_val("sw_e_char", last_ascii_sw, 8'h45);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
